bitstream_frame_arbiter: RTL and testbench

//   Shares the DCU byte FIFO + bit serializer between two byte sources (0: background/map, 1: sprite/overlay).

---
 rtl/bitstream_frame_arbiter.sv | 139 +++++++++++++
 tb/tb_bitstream_frame_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bitstream_frame_arbiter.sv
// Round-robin frame arbiter sharing the DCU byte FIFO and bit serializer between two byte sources.
// Define BS_ARB_FIXED_PRIO_EN to make source 0 always win simultaneous requests.
module bitstream_frame_arbiter #(
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned GAP_CYCLES = 2000,
    parameter int unsigned GAP_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       data0,
    input  logic [7:0]       data1,
    input  logic             valid0,
    input  logic             valid1,
    output logic             ready0,
    output logic             ready1,
    input  logic             fifo_wfull,
    input  logic             fifo_rempty,
    input  logic             bs_rempty,
    output logic             fifo_winc,
    output logic [7:0]       fifo_wdata,
    output logic             bs_enb,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, GAP} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             empty_q;
    logic             win1;
    logic             sel1;
    logic             accept;
    logic             drained;
    logic             gap_end;

    assign sel1    = gnt[1];
    assign drained = fifo_rempty && bs_rempty && empty_q;
    assign gap_end = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef BS_ARB_FIXED_PRIO_EN
    assign win1 = !req0;
`else
    logic prefer1;

    // Winner is the preferred source on a tie; otherwise whichever source is requesting.
    assign win1 = (req0 && req1) ? prefer1 : !req0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prefer1 <= 1'b0;
        end else if (state == IDLE && (req0 || req1)) begin
            prefer1 <= !win1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = STREAM;
            STREAM:  if (byte_cnt == '0 || (accept && byte_cnt == LEN_W'(1))) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (state == STREAM && byte_cnt != '0) begin
            ready0 = !sel1 && !fifo_wfull;
            ready1 = sel1 && !fifo_wfull;
        end
        accept     = sel1 ? (valid1 && ready1) : (valid0 && ready0);
        fifo_winc  = accept;
        fifo_wdata = sel1 ? data1 : data0;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            empty_q  <= 1'b0;
            bs_enb   <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
        end else begin
            done0  <= 1'b0;
            done1  <= 1'b0;
            bs_enb <= (state_nxt == STREAM) || (state_nxt == DRAIN);
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt      <= win1 ? 2'b10 : 2'b01;
                        byte_cnt <= win1 ? len1 : len0;
                    end
                end
                STREAM: begin
                    if (accept) byte_cnt <= byte_cnt - LEN_W'(1);
                end
                DRAIN: begin
                    // empty_q remembers that both drain flags were high on the previous DRAIN cycle.
                    empty_q <= fifo_rempty && bs_rempty;
                    if (drained) begin
                        gnt     <= '0;
                        done0   <= !sel1;
                        done1   <= sel1;
                        empty_q <= 1'b0;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_frame_arbiter.sv
// Directed self-checking bench for bitstream_frame_arbiter (short GAP for quick runs).
// Expectations follow BS_ARB_FIXED_PRIO_EN when the bench is built with it defined.
module tb_bitstream_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [11:0] len0 = '0, len1 = '0;
    logic [7:0]  data0 = '0, data1 = '0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        ready0, ready1;
    logic        fifo_wfull = 1'b0;
    logic        fifo_rempty = 1'b1;
    logic        bs_rempty = 1'b1;
    logic        fifo_winc;
    logic [7:0]  fifo_wdata;
    logic        bs_enb;
    logic [1:0]  gnt;
    logic        done0, done1, busy;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  n0 = '0, n1 = '0;
    logic        stall_now = 1'b0;
    logic        bs_low_now = 1'b0;
    int          w;

    bitstream_frame_arbiter #(
        .LEN_W(12),
        .GAP_CYCLES(4),
        .GAP_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .data0(data0), .data1(data1), .valid0(valid0), .valid1(valid1),
        .ready0(ready0), .ready1(ready1),
        .fifo_wfull(fifo_wfull), .fifo_rempty(fifo_rempty), .bs_rempty(bs_rempty),
        .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata), .bs_enb(bs_enb), .gnt(gnt),
        .done0(done0), .done1(done1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; drive this cycle's inputs, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        data0      = 8'h10 + n0;
        data1      = 8'h80 + n1;
        fifo_wfull = stall_now;
        bs_rempty  = !bs_low_now;
        #1;
    endtask

    task automatic run_frame(input logic [1:0] exp_gnt, input int exp_wait, input int exp_bytes,
                             input int exp_done_k, input int stall_at, input int stall_n,
                             input int bs_low_at);
        int         wt, k, nb;
        logic       bad;
        logic [7:0] exp_b;
        stall_now  = 1'b0;
        bs_low_now = 1'b0;
        wt = 0;
        while (gnt == 2'b00 && wt < 60) begin
            tick();
            wt++;
        end
        if (exp_wait > 0) check("grant_latency", wt, exp_wait);
        check("grant", 32'(gnt), 32'(exp_gnt));
        k = 0; nb = 0; bad = 1'b0;
        while (k < 400) begin
            if (done0 || done1) break;
            if (!bs_enb || !busy) bad = 1'b1;
            if (exp_gnt[0] ? ready1 : ready0) bad = 1'b1;
            if (fifo_wfull) begin
                check("stall_ready", 32'({ready1, ready0}), 32'd0);
                check("stall_winc", 32'(fifo_winc), 32'd0);
            end
            if (fifo_winc) begin
                exp_b = exp_gnt[0] ? 8'h10 + n0 : 8'h80 + n1;
                check("wdata", 32'(fifo_wdata), 32'(exp_b));
                nb++;
                if (exp_gnt[0]) n0 = n0 + 8'd1;
                else            n1 = n1 + 8'd1;
            end
            k++;
            stall_now  = (k >= stall_at) && (k < stall_at + stall_n);
            bs_low_now = (k == bs_low_at);
            tick();
        end
        stall_now  = 1'b0;
        bs_low_now = 1'b0;
        check("done_cycle", k, exp_done_k);
        check("byte_count", nb, exp_bytes);
        check("done_vec", 32'({done1, done0}), 32'(exp_gnt));
        check("gnt_clear", 32'(gnt), 32'd0);
        check("enb_off_gap", 32'(bs_enb), 32'd0);
        check("busy_gap", 32'(busy), 32'd1);
        check("frame_ctl", 32'(bad), 32'd0);
    endtask

    initial begin
        valid0 = 1'b1;
        valid1 = 1'b1;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_enb", 32'(bs_enb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'({done1, done0}), 32'd0);
        check("rst_ready", 32'({ready1, ready0}), 32'd0);
        check("rst_winc", 32'(fifo_winc), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single 3-byte frame from source 0, then the idle gap
        req0 = 1'b1; len0 = 12'd3;
        run_frame(2'b01, 1, 3, 5, 0, 0, -1);
        req0 = 1'b0;
        tick();
        check("done_one_cycle", 32'(done0), 32'd0);
        tick();
        tick();
        check("gap_busy", 32'(busy), 32'd1);
        tick();
        check("gap_end_idle", 32'(busy), 32'd0);

        // 2: both sources requesting, grants alternate (or stay on source 0 with fixed priority)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; len0 = 12'd2; len1 = 12'd2;
`ifdef BS_ARB_FIXED_PRIO_EN
        run_frame(2'b01, 1, 2, 4, 0, 0, -1);
        run_frame(2'b01, 5, 2, 4, 0, 0, -1);
        run_frame(2'b01, 5, 2, 4, 0, 0, -1);
        run_frame(2'b01, 5, 2, 4, 0, 0, -1);
`else
        run_frame(2'b01, 1, 2, 4, 0, 0, -1);
        run_frame(2'b10, 5, 2, 4, 0, 0, -1);
        run_frame(2'b01, 5, 2, 4, 0, 0, -1);
        run_frame(2'b10, 5, 2, 4, 0, 0, -1);
`endif
        req1 = 1'b0;

        // 3: 6-byte frame with FIFO full for 5 cycles after two bytes
        req0 = 1'b1; len0 = 12'd6;
        run_frame(2'b01, 5, 6, 13, 2, 5, -1);
        req0 = 1'b0;

        // 4: zero-length frame from source 1
        req1 = 1'b1; len1 = 12'd0;
        run_frame(2'b10, 5, 0, 3, 0, 0, -1);
        req1 = 1'b0;

        // 5: serializer empty flag drops once during DRAIN (1,0,1,1)
        req0 = 1'b1; len0 = 12'd1;
        run_frame(2'b01, 5, 1, 5, 0, 0, 2);
        req0 = 1'b0;

        // 6: reset in the middle of a source-1 frame, then a normal source-0 frame
        req1 = 1'b1; len1 = 12'd5;
        w = 0;
        while (gnt == 2'b00 && w < 60) begin
            tick();
            w++;
        end
        check("rstmid_grant_latency", w, 5);
        check("rstmid_grant", 32'(gnt), 32'b10);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_gnt", 32'(gnt), 32'd0);
        check("rstmid_enb", 32'(bs_enb), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ready", 32'({ready1, ready0}), 32'd0);
        check("rstmid_winc", 32'(fifo_winc), 32'd0);
        rst_n = 1'b1; req1 = 1'b0;
        req0 = 1'b1; len0 = 12'd2;
        run_frame(2'b01, 1, 2, 4, 0, 0, -1);
        req0 = 1'b0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
